// File: rtl/csr_arbiter.sv
// csr_arbiter: shares the CSR file port between exec and trap units.
// One registered transaction at a time; trap may lock the file.
module csr_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_req_valid,
  output logic          ex_req_ready,
  input  logic [AW-1:0] ex_req_a,
  input  logic [DW-1:0] ex_req_d,
  input  logic [1:0]    ex_req_t,
  output logic          ex_resp_valid,
  output logic [DW-1:0] ex_resp_d,
  output logic          ex_resp_exists,
  input  logic          tr_req_valid,
  output logic          tr_req_ready,
  input  logic [AW-1:0] tr_req_a,
  input  logic [DW-1:0] tr_req_d,
  input  logic [1:0]    tr_req_t,
  input  logic          tr_req_lock,
  output logic          tr_resp_valid,
  output logic [DW-1:0] tr_resp_d,
  output logic          tr_resp_exists,
  output logic          csr_req_valid,
  input  logic          csr_req_ready,
  output logic [AW-1:0] csr_req_a,
  output logic [DW-1:0] csr_req_d,
  output logic [1:0]    csr_req_t,
  input  logic          csr_resp_valid,
  input  logic [DW-1:0] csr_resp_d,
  input  logic          csr_resp_exists,
  output logic          busy
);

  localparam int SW =
    (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          owner;
  logic [AW-1:0] req_a;
  logic [DW-1:0] req_d;
  logic [1:0]    req_t;
  logic          locked;
  logic [SW-1:0] starve_cnt;
  logic          starve_hit;
  logic          cnt_full;

  assign cnt_full   = (starve_cnt == SW'(STARVE_LIMIT));
  assign starve_hit = (STARVE_LIMIT != 0) && cnt_full;

  // Grant selection, handshakes and next-state decode.
  always_comb begin
    state_nx      = state;
    ex_req_ready  = 1'b0;
    tr_req_ready  = 1'b0;
    csr_req_valid = 1'b0;
    ex_resp_valid = 1'b0;
    tr_resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (!locked && ex_req_valid &&
            (!tr_req_valid || starve_hit))
          ex_req_ready = 1'b1;
        else if (tr_req_valid)
          tr_req_ready = 1'b1;
        if (ex_req_ready || tr_req_ready)
          state_nx = ISSUE;
      end
      ISSUE: begin
        csr_req_valid = 1'b1;
        if (csr_req_ready)
          state_nx = RESP;
      end
      RESP: begin
        if (csr_resp_valid) begin
          ex_resp_valid = !owner;
          tr_resp_valid = owner;
          state_nx      = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Capture the winning request and remember who owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner <= 1'b0;
      req_a <= '0;
      req_d <= '0;
      req_t <= '0;
    end else if (ex_req_ready) begin
      owner <= 1'b0;
      req_a <= ex_req_a;
      req_d <= ex_req_d;
      req_t <= ex_req_t;
    end else if (tr_req_ready) begin
      owner <= 1'b1;
      req_a <= tr_req_a;
      req_d <= tr_req_d;
      req_t <= tr_req_t;
    end
  end

  // Trap lock and exec anti-starvation bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      locked     <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if (tr_req_ready)
        locked <= tr_req_lock;
      else if (state == IDLE && !tr_req_valid && !tr_req_lock)
        locked <= 1'b0;
      if (ex_req_ready)
        starve_cnt <= '0;
      else if (tr_req_ready && ex_req_valid && !cnt_full)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign csr_req_a      = req_a;
  assign csr_req_d      = req_d;
  assign csr_req_t      = req_t;
  assign ex_resp_d      = ex_resp_valid ? csr_resp_d : '0;
  assign ex_resp_exists = ex_resp_valid & csr_resp_exists;
  assign tr_resp_d      = tr_resp_valid ? csr_resp_d : '0;
  assign tr_resp_exists = tr_resp_valid & csr_resp_exists;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_csr_arbiter.sv
// tb_csr_arbiter: directed bench for csr_arbiter.
// Hand-computed expectations, one task per scenario.
module tb_csr_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_req_valid;
  logic          ex_req_ready;
  logic [AW-1:0] ex_req_a;
  logic [DW-1:0] ex_req_d;
  logic [1:0]    ex_req_t;
  logic          ex_resp_valid;
  logic [DW-1:0] ex_resp_d;
  logic          ex_resp_exists;
  logic          tr_req_valid;
  logic          tr_req_ready;
  logic [AW-1:0] tr_req_a;
  logic [DW-1:0] tr_req_d;
  logic [1:0]    tr_req_t;
  logic          tr_req_lock;
  logic          tr_resp_valid;
  logic [DW-1:0] tr_resp_d;
  logic          tr_resp_exists;
  logic          csr_req_valid;
  logic          csr_req_ready;
  logic [AW-1:0] csr_req_a;
  logic [DW-1:0] csr_req_d;
  logic [1:0]    csr_req_t;
  logic          csr_resp_valid;
  logic [DW-1:0] csr_resp_d;
  logic          csr_resp_exists;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic          got_ex;
  logic          got_tr;
  logic [DW-1:0] got_d;
  logic          got_x;

  csr_arbiter #(.STARVE_LIMIT(4), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .ex_req_valid(ex_req_valid), .ex_req_ready(ex_req_ready),
    .ex_req_a(ex_req_a), .ex_req_d(ex_req_d), .ex_req_t(ex_req_t),
    .ex_resp_valid(ex_resp_valid), .ex_resp_d(ex_resp_d),
    .ex_resp_exists(ex_resp_exists),
    .tr_req_valid(tr_req_valid), .tr_req_ready(tr_req_ready),
    .tr_req_a(tr_req_a), .tr_req_d(tr_req_d), .tr_req_t(tr_req_t),
    .tr_req_lock(tr_req_lock),
    .tr_resp_valid(tr_resp_valid), .tr_resp_d(tr_resp_d),
    .tr_resp_exists(tr_resp_exists),
    .csr_req_valid(csr_req_valid), .csr_req_ready(csr_req_ready),
    .csr_req_a(csr_req_a), .csr_req_d(csr_req_d),
    .csr_req_t(csr_req_t),
    .csr_resp_valid(csr_resp_valid), .csr_resp_d(csr_resp_d),
    .csr_resp_exists(csr_resp_exists),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From the first ISSUE cycle: accept, then respond one cycle later.
  task automatic run_file(input logic [DW-1:0] d, input logic x);
    csr_req_ready = 1'b1;
    tick();
    csr_req_ready   = 1'b0;
    csr_resp_valid  = 1'b1;
    csr_resp_d      = d;
    csr_resp_exists = x;
    #1;
    got_ex = ex_resp_valid;
    got_tr = tr_resp_valid;
    got_d  = ex_resp_valid ? ex_resp_d : tr_resp_d;
    got_x  = ex_resp_valid ? ex_resp_exists : tr_resp_exists;
    tick();
    csr_resp_valid  = 1'b0;
    csr_resp_d      = '0;
    csr_resp_exists = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    n_tests++;
    if (csr_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_csr_valid got %b want 0", csr_req_valid);
    end
    n_tests++;
    if ({ex_resp_valid, tr_resp_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_resp got %b%b want 00",
               ex_resp_valid, tr_resp_valid);
    end
    n_tests++;
    if ({ex_req_ready, tr_req_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready got %b%b want 00",
               ex_req_ready, tr_req_ready);
    end
    n_tests++;
    if ({csr_req_a, csr_req_d, csr_req_t} !== '0) begin
      n_fail++;
      $display("FAIL reset_regs got a=%h d=%h t=%b want 0",
               csr_req_a, csr_req_d, csr_req_t);
    end
    tick();
  endtask

  task automatic test_single_ex();
    ex_req_valid = 1'b1;
    ex_req_a     = 12'h300;
    ex_req_d     = 32'h8;
    ex_req_t     = 2'b01;
    #1;
    n_tests++;
    if ({ex_req_ready, tr_req_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_grant got %b%b want 10",
               ex_req_ready, tr_req_ready);
    end
    tick();
    ex_req_valid = 1'b0;
    #1;
    n_tests++;
    if (csr_req_valid !== 1'b1 || csr_req_a !== 12'h300 ||
        csr_req_t !== 2'b01 || csr_req_d !== 32'h8) begin
      n_fail++;
      $display("FAIL single_issue got v=%b a=%h d=%h t=%b want 1 300 8 01",
               csr_req_valid, csr_req_a, csr_req_d, csr_req_t);
    end
    run_file(32'h1800, 1'b1);
    n_tests++;
    if ({got_ex, got_tr} !== 2'b10 || got_d !== 32'h1800 ||
        got_x !== 1'b1) begin
      n_fail++;
      $display("FAIL single_resp got ex=%b tr=%b d=%h x=%b want 1 0 1800 1",
               got_ex, got_tr, got_d, got_x);
    end
    n_tests++;
    if (busy !== 1'b0 || ex_resp_d !== '0) begin
      n_fail++;
      $display("FAIL single_done got busy=%b d=%h want 0 0",
               busy, ex_resp_d);
    end
  endtask

  task automatic test_starve();
    logic [5:0] seq;
    logic [5:0] want;
    want         = 6'b101111;
    ex_req_valid = 1'b1;
    tr_req_valid = 1'b1;
    tr_req_lock  = 1'b0;
    ex_req_a     = 12'h305;
    tr_req_a     = 12'h341;
    ex_req_t     = 2'b10;
    tr_req_t     = 2'b01;
    for (int i = 0; i < 6; i++) begin
      #1;
      seq[i] = tr_req_ready & ~ex_req_ready;
      if (i == 4) begin
        n_tests++;
        if (dut.starve_cnt !== 3'd4) begin
          n_fail++;
          $display("FAIL starve_cnt_full got %0d want 4", dut.starve_cnt);
        end
      end
      tick();
      if (i == 4) begin
        n_tests++;
        if (dut.starve_cnt !== 3'd0) begin
          n_fail++;
          $display("FAIL starve_cnt_clear got %0d want 0",
                   dut.starve_cnt);
        end
      end
      run_file(32'h10 + i, 1'b1);
      n_tests++;
      if ({got_tr, got_ex} !== {want[i], ~want[i]}) begin
        n_fail++;
        $display("FAIL starve_route_%0d got tr=%b ex=%b want tr=%b",
                 i, got_tr, got_ex, want[i]);
      end
    end
    n_tests++;
    if (seq !== want) begin
      n_fail++;
      $display("FAIL starve_order got %b want %b", seq, want);
    end
    ex_req_valid = 1'b0;
    tr_req_valid = 1'b0;
  endtask

  task automatic test_lock();
    ex_req_valid = 1'b1;
    ex_req_a     = 12'h304;
    for (int i = 0; i < 3; i++) begin
      tr_req_valid = 1'b1;
      tr_req_lock  = (i < 2);
      tr_req_a     = 12'h341 + i;
      tr_req_d     = 32'hA0 + i;
      #1;
      n_tests++;
      if ({ex_req_ready, tr_req_ready} !== 2'b01) begin
        n_fail++;
        $display("FAIL lock_grant_%0d got ex=%b tr=%b want 0 1",
                 i, ex_req_ready, tr_req_ready);
      end
      tick();
      tr_req_valid = 1'b0;
      #1;
      n_tests++;
      if (csr_req_a !== 12'h341 + i) begin
        n_fail++;
        $display("FAIL lock_addr_%0d got %h want %h",
                 i, csr_req_a, 12'h341 + i);
      end
      run_file(32'h0, 1'b1);
      if (i == 0) begin
        #1;
        n_tests++;
        if (ex_req_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL lock_gap got ex_ready=%b want 0", ex_req_ready);
        end
        tick();
      end
    end
    tr_req_lock = 1'b0;
    #1;
    n_tests++;
    if (ex_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_release got ex_ready=%b want 1", ex_req_ready);
    end
    tick();
    ex_req_valid = 1'b0;
    run_file(32'h5, 1'b1);
    n_tests++;
    if ({got_ex, got_tr} !== 2'b10) begin
      n_fail++;
      $display("FAIL lock_ex_resp got ex=%b tr=%b want 1 0",
               got_ex, got_tr);
    end
  endtask

  task automatic test_hold();
    tr_req_valid = 1'b1;
    tr_req_lock  = 1'b0;
    tr_req_a     = 12'h305;
    tr_req_d     = 32'h100;
    tr_req_t     = 2'b10;
    tick();
    tr_req_valid = 1'b0;
    tr_req_a     = 12'h007;
    tr_req_d     = 32'hFFFF;
    tr_req_t     = 2'b11;
    ex_req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if (csr_req_valid !== 1'b1 || csr_req_a !== 12'h305 ||
          csr_req_d !== 32'h100 || csr_req_t !== 2'b10 ||
          ex_req_ready !== 1'b0 || tr_req_ready !== 1'b0 ||
          busy !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_%0d got v=%b a=%h d=%h t=%b rdy=%b%b busy=%b",
                 i, csr_req_valid, csr_req_a, csr_req_d, csr_req_t,
                 ex_req_ready, tr_req_ready, busy);
      end
      tick();
    end
    ex_req_valid = 1'b0;
    run_file(32'hAB, 1'b1);
    n_tests++;
    if ({got_ex, got_tr} !== 2'b01 || got_d !== 32'hAB) begin
      n_fail++;
      $display("FAIL hold_resp got ex=%b tr=%b d=%h want 0 1 ab",
               got_ex, got_tr, got_d);
    end
  endtask

  task automatic test_noexist();
    ex_req_valid = 1'b1;
    ex_req_a     = 12'hFFF;
    ex_req_t     = 2'b11;
    ex_req_d     = 32'h1;
    tick();
    ex_req_valid = 1'b0;
    run_file(32'hDEAD, 1'b0);
    n_tests++;
    if ({got_ex, got_tr} !== 2'b10 || got_x !== 1'b0 ||
        got_d !== 32'hDEAD) begin
      n_fail++;
      $display("FAIL noexist got ex=%b tr=%b x=%b d=%h want 1 0 0 dead",
               got_ex, got_tr, got_x, got_d);
    end
  endtask

  task automatic test_reset_resp();
    tr_req_valid = 1'b1;
    tr_req_lock  = 1'b1;
    tr_req_a     = 12'h342;
    tick();
    tr_req_valid  = 1'b0;
    csr_req_ready = 1'b1;
    tick();
    csr_req_ready = 1'b0;
    rst           = 1'b1;
    tick();
    rst             = 1'b0;
    tr_req_lock     = 1'b0;
    csr_resp_valid  = 1'b1;
    csr_resp_d      = 32'h55;
    csr_resp_exists = 1'b1;
    ex_req_valid    = 1'b1;
    ex_req_a        = 12'h300;
    #1;
    n_tests++;
    if ({ex_resp_valid, tr_resp_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_late_resp got %b%b want 00",
               ex_resp_valid, tr_resp_valid);
    end
    n_tests++;
    if (busy !== 1'b0 || dut.locked !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_state got busy=%b locked=%b want 0 0",
               busy, dut.locked);
    end
    n_tests++;
    if (ex_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ex_grant got %b want 1", ex_req_ready);
    end
    tick();
    csr_resp_valid = 1'b0;
    ex_req_valid   = 1'b0;
    run_file(32'h77, 1'b1);
    n_tests++;
    if ({got_ex, got_tr} !== 2'b10 || got_d !== 32'h77) begin
      n_fail++;
      $display("FAIL rst_after got ex=%b tr=%b d=%h want 1 0 77",
               got_ex, got_tr, got_d);
    end
  endtask

  initial begin
    rst             = 1'b1;
    ex_req_valid    = 1'b0;
    ex_req_a        = '0;
    ex_req_d        = '0;
    ex_req_t        = '0;
    tr_req_valid    = 1'b0;
    tr_req_a        = '0;
    tr_req_d        = '0;
    tr_req_t        = '0;
    tr_req_lock     = 1'b0;
    csr_req_ready   = 1'b0;
    csr_resp_valid  = 1'b0;
    csr_resp_d      = '0;
    csr_resp_exists = 1'b0;
    test_reset();
    test_single_ex();
    test_starve();
    test_lock();
    test_hold();
    test_noexist();
    test_reset_resp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_arbiter.md
Name: csr_arbiter

Overview:
- Shares the single CSR file request/response port between two requesters: the exec-stage CSR unit (port "ex") and the trap/commit unit (port "tr").
- The trap unit writes mepc/mcause/mtval and similar CSRs, and may lock the file across a multi-access sequence so the accesses are atomic.
- The block registers one transaction at a time, forwards it to the CSR file and routes the response back to the requester that issued it.
- It sits between the exec CSR unit, the trap unit and the CSR file.

Parameters:
- STARVE_LIMIT, 4: consecutive exec losses after which exec wins one unlocked arbitration; 0 disables the anti-starvation rule.
- AW, 12: CSR address width.
- DW, 32: CSR data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ex_req_valid  in  1  exec request valid
- ex_req_ready  out  1  exec request accepted
- ex_req_a  in  AW  exec CSR address
- ex_req_d  in  DW  exec write/mask data
- ex_req_t  in  2  exec op: 01 RW, 10 RS, 11 RC
- ex_resp_valid  out  1  one-cycle response pulse to exec
- ex_resp_d  out  DW  old CSR value
- ex_resp_exists  out  1  CSR exists
- tr_req_valid/tr_req_ready/tr_req_a/tr_req_d/tr_req_t  same as ex_*  trap request
- tr_req_lock  in  1  keep grant with trap after this access
- tr_resp_valid/tr_resp_d/tr_resp_exists  out  same as ex_resp_*
- csr_req_valid  out  1  request to CSR file
- csr_req_ready  in  1  CSR file accepts
- csr_req_a/csr_req_d/csr_req_t  out  AW/DW/2  registered request fields
- csr_resp_valid  in  1  CSR file response
- csr_resp_d  in  DW  response data
- csr_resp_exists  in  1  response exists flag
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, ISSUE, RESP. Registers: owner (0=ex, 1=tr), req_a/d/t, locked, starve_cnt (width to hold STARVE_LIMIT).
- IDLE:
  - Winner chosen combinationally from the valids. The winner's req_ready=1 in the same cycle; the loser's ready=0.
  - Fields and owner are captured; next state is ISSUE.
  - Both ready signals are 0 in ISSUE and RESP.
- Priority in IDLE:
  - locked=1: only trap may be granted; ex is never granted.
  - Otherwise, both valid and starve_cnt==STARVE_LIMIT with STARVE_LIMIT!=0: ex wins.
  - Otherwise trap wins. A single valid requester wins.
- starve_cnt:
  - +1 in each IDLE cycle where both are valid and trap wins (saturating).
  - Cleared on every ex grant.
- locked:
  - Set on a trap grant with tr_req_lock=1.
  - Cleared on a trap grant with tr_req_lock=0.
  - Also cleared in IDLE when tr_req_valid=0 and tr_req_lock=0.
- ISSUE:
  - csr_req_valid=1, fields driven from registers and held stable until csr_req_ready.
  - On handshake, go to RESP. No abandonment.
- RESP:
  - Wait for csr_resp_valid. In that cycle, drive the owner's resp_valid=1 with csr_resp_d/exists passed through combinationally, then go to IDLE.
  - The non-owner resp_valid is 0. Responses have no ready; requesters must sink them.
- csr_resp_valid outside RESP is ignored.
- Minimum latency: request accepted cycle N, csr_req_valid cycle N+1, response cycle N+2 if the file is ready and responds the next cycle. Back-to-back grants every 3 cycles minimum.
- Ops pass through unchanged. No filtering of t=00 or RO writes; upstream units handle those.
- Outputs when not active:
  - csr_req_a/d/t show register contents; they are don't-care when csr_req_valid=0.
  - resp_d outputs are 0 when their valid=0.
- Reset:
  - state=IDLE, locked=0, starve_cnt=0, owner=0, req regs=0.
  - All valid/ready outputs 0 except the combinational IDLE readies; busy=0.
  - Reset mid-ISSUE/RESP drops the transaction. A late csr_resp_valid after reset is ignored.

Test Plan:
- Single ex RW to 0x300, d=0x8, file returns d=0x1800, exists=1 -> ex_req_ready cycle 0, csr_req_valid cycle 1 with a=0x300 t=01, ex_resp_valid cycle 2 with d=0x1800, tr_resp_valid never set.
- Both valid every cycle, tr_req_lock=0, STARVE_LIMIT=4 -> trap granted 4 times, 5th grant to ex, starve_cnt returns to 0.
- Trap writes 0x341, 0x342, 0x343 with lock=1,1,0 while ex_req_valid held high -> all three trap accesses complete before ex_req_ready asserts; ex then granted.
- csr_req_ready held low 5 cycles in ISSUE -> csr_req_a/d/t stable, both req_ready 0, busy 1; response routed correctly after release.
- csr_resp_exists=0 for a=0xFFF -> owner receives resp_valid=1 with exists=0 and the returned d.
- rst asserted in RESP, then csr_resp_valid pulsed the next cycle -> no resp_valid on either port, state IDLE, locked=0.
